// File: rtl/ex_stage_muldiv.sv
// ex_stage_muldiv: MIPS execute stage. Forwarding muxes, single-cycle ALU, branch-target adder,
// iterative unsigned multiply/divide writing HI/LO, and registered EX/MEM outputs.
module ex_stage_muldiv #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            ALUCtl,
  input  logic                  ALUSrc,
  input  logic                  RegDst,
  input  logic                  RegWrite_in,
  input  logic                  MemtoReg_in,
  input  logic                  MemRead_in,
  input  logic                  MemWrite_in,
  input  logic                  Branch_in,
  input  logic [DATA_W-1:0]     PCAddResult,
  input  logic [DATA_W-1:0]     ReadData1,
  input  logic [DATA_W-1:0]     ReadData2_in,
  input  logic [DATA_W-1:0]     SignExtResult,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [1:0]            FwdA,
  input  logic [1:0]            FwdB,
  input  logic [DATA_W-1:0]     FwdMem,
  input  logic [DATA_W-1:0]     FwdWb,
  output logic                  out_valid,
  output logic                  RegWrite_out,
  output logic                  MemtoReg_out,
  output logic                  MemRead_out,
  output logic                  MemWrite_out,
  output logic                  Branch_out,
  output logic [DATA_W-1:0]     BranchTarget,
  output logic [DATA_W-1:0]     ALUResult,
  output logic                  Zero,
  output logic [DATA_W-1:0]     WriteData,
  output logic [REG_ADDR_W-1:0] WriteReg
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  localparam logic [3:0] OpAnd = 4'd0,  OpOr   = 4'd1,  OpAdd  = 4'd2,  OpSub  = 4'd3;
  localparam logic [3:0] OpSlt = 4'd4,  OpNor  = 4'd5,  OpXor  = 4'd6,  OpSll  = 4'd7;
  localparam logic [3:0] OpSrl = 4'd8,  OpSra  = 4'd9,  OpMult = 4'd10, OpDiv  = 4'd11;
  localparam logic [3:0] OpMfhi = 4'd12, OpMflo = 4'd13, OpSltu = 4'd14, OpLui = 4'd15;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e                  stateQ, stateD;
  logic [CntW-1:0]         cntQ, cntD;
  logic [DATA_W-1:0]       hiQ, loQ;
  logic [DATA_W-1:0]       accHiQ, accHiD, accLoQ, accLoD, opndQ, opndD;
  logic                    memtoRegQ;
  logic [REG_ADDR_W-1:0]   wregQ, writeRegSel;
  logic [DATA_W-1:0]       opA, bFwd, opB, aluRes, mulAddend;
  logic [DATA_W:0]         mulSum, divShift, divTrial;
  logic [4:0]              shamt;
  logic                    accept, isMulDiv, done;

  assign in_ready    = (stateQ == StIdle);
  assign accept      = in_valid && in_ready && !Flush;
  assign isMulDiv    = (ALUCtl == OpMult) || (ALUCtl == OpDiv);
  assign opB         = ALUSrc ? SignExtResult : bFwd;
  assign shamt       = 5'(SignExtResult >> 6);
  assign writeRegSel = RegDst ? rd : rt;
  assign Zero        = (ALUResult == '0);

  // Forwarding muxes for both operands; 11 falls back to the register file
  always_comb begin
    case (FwdA)
      2'b10:   opA = FwdMem;
      2'b01:   opA = FwdWb;
      default: opA = ReadData1;
    endcase
    case (FwdB)
      2'b10:   bFwd = FwdMem;
      2'b01:   bFwd = FwdWb;
      default: bFwd = ReadData2_in;
    endcase
  end

  // Single-cycle ALU; MULTU/DIVU produce their result later through HI/LO
  always_comb begin
    aluRes = '0;
    case (ALUCtl)
      OpAnd:   aluRes = opA & opB;
      OpOr:    aluRes = opA | opB;
      OpAdd:   aluRes = opA + opB;
      OpSub:   aluRes = opA - opB;
      OpSlt:   aluRes = {{(DATA_W-1){1'b0}}, $signed(opA) < $signed(opB)};
      OpNor:   aluRes = ~(opA | opB);
      OpXor:   aluRes = opA ^ opB;
      OpSll:   aluRes = opB << shamt;
      OpSrl:   aluRes = opB >> shamt;
      OpSra:   aluRes = $signed(opB) >>> shamt;
      OpMfhi:  aluRes = hiQ;
      OpMflo:  aluRes = loQ;
      OpSltu:  aluRes = {{(DATA_W-1){1'b0}}, opA < opB};
      OpLui:   aluRes = opB << 16;
      default: aluRes = '0;
    endcase
  end

  // Shift-add step: {acc_hi, acc_lo} holds partial product over multiplier bits
  assign mulAddend = accLoQ[0] ? opndQ : '0;
  assign mulSum    = {1'b0, accHiQ} + {1'b0, mulAddend};
  // Restoring step: acc_hi is the remainder, acc_lo shifts dividend out / quotient in.
  // A zero divisor never restores, so the quotient fills with ones and the remainder ends at A.
  assign divShift  = {accHiQ, accLoQ[DATA_W-1]};
  assign divTrial  = divShift - {1'b0, opndQ};

  // Mul/div FSM next state; flush while busy aborts without completing
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    accHiD = accHiQ;
    accLoD = accLoQ;
    opndD  = opndQ;
    done   = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (accept && isMulDiv) begin
          stateD = (ALUCtl == OpMult) ? StMul : StDiv;
          cntD   = CntW'(DATA_W);
          accHiD = '0;
          accLoD = (ALUCtl == OpMult) ? opB : opA;
          opndD  = (ALUCtl == OpMult) ? opA : opB;
        end
      end
      StMul: begin
        accHiD = mulSum[DATA_W:1];
        accLoD = {mulSum[0], accLoQ[DATA_W-1:1]};
        cntD   = cntQ - 1'b1;
        if (cntQ == CntW'(1)) begin
          stateD = StIdle;
          done   = 1'b1;
        end
      end
      StDiv: begin
        accHiD = divTrial[DATA_W] ? divShift[DATA_W-1:0] : divTrial[DATA_W-1:0];
        accLoD = {accLoQ[DATA_W-2:0], ~divTrial[DATA_W]};
        cntD   = cntQ - 1'b1;
        if (cntQ == CntW'(1)) begin
          stateD = StIdle;
          done   = 1'b1;
        end
      end
      default: stateD = StIdle;
    endcase
    if (Flush && (stateQ != StIdle)) begin
      stateD = StIdle;
      cntD   = '0;
      done   = 1'b0;
    end
  end

  // FSM state, iteration datapath, HI/LO and the mul/div instruction's pass-through fields
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stateQ    <= StIdle;
      cntQ      <= '0;
      accHiQ    <= '0;
      accLoQ    <= '0;
      opndQ     <= '0;
      hiQ       <= '0;
      loQ       <= '0;
      memtoRegQ <= 1'b0;
      wregQ     <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      accHiQ <= accHiD;
      accLoQ <= accLoD;
      opndQ  <= opndD;
      if (done) begin
        hiQ <= accHiD;
        loQ <= accLoD;
      end
      if (accept && isMulDiv) begin
        memtoRegQ <= MemtoReg_in;
        wregQ     <= writeRegSel;
      end
    end
  end

  // EX/MEM register: completion beats a new accept (they never coincide); else bubble
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      out_valid    <= 1'b0;
      RegWrite_out <= 1'b0;
      MemtoReg_out <= 1'b0;
      MemRead_out  <= 1'b0;
      MemWrite_out <= 1'b0;
      Branch_out   <= 1'b0;
      BranchTarget <= '0;
      ALUResult    <= '0;
      WriteData    <= '0;
      WriteReg     <= '0;
    end else if (done) begin
      out_valid    <= 1'b1;
      RegWrite_out <= 1'b0;
      MemtoReg_out <= memtoRegQ;
      MemRead_out  <= 1'b0;
      MemWrite_out <= 1'b0;
      Branch_out   <= 1'b0;
      BranchTarget <= '0;
      ALUResult    <= accLoD;
      WriteData    <= '0;
      WriteReg     <= wregQ;
    end else if (accept && !isMulDiv) begin
      out_valid    <= 1'b1;
      RegWrite_out <= RegWrite_in;
      MemtoReg_out <= MemtoReg_in;
      MemRead_out  <= MemRead_in;
      MemWrite_out <= MemWrite_in;
      Branch_out   <= Branch_in;
      BranchTarget <= PCAddResult + (SignExtResult << 2);
      ALUResult    <= aluRes;
      WriteData    <= bFwd;
      WriteReg     <= writeRegSel;
    end else begin
      out_valid    <= 1'b0;
      RegWrite_out <= 1'b0;
      MemtoReg_out <= 1'b0;
      MemRead_out  <= 1'b0;
      MemWrite_out <= 1'b0;
      Branch_out   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// tb_ex_stage_muldiv: directed plus randomized checks of ex_stage_muldiv against an
// arithmetic reference model (64-bit product, native / and %).
`timescale 1ns/1ps
module tb_ex_stage_muldiv;

  logic        Clk = 1'b0;
  logic        Reset, Flush, in_valid, in_ready;
  logic [3:0]  ALUCtl;
  logic        ALUSrc, RegDst, RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, Branch_in;
  logic [31:0] PCAddResult, ReadData1, ReadData2_in, SignExtResult, FwdMem, FwdWb;
  logic [4:0]  rt, rd;
  logic [1:0]  FwdA, FwdB;
  logic        out_valid, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, Branch_out;
  logic [31:0] BranchTarget, ALUResult, WriteData;
  logic        Zero;
  logic [4:0]  WriteReg;

  int nTests = 0;
  int nFail  = 0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;

  ex_stage_muldiv #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .in_valid(in_valid), .in_ready(in_ready),
    .ALUCtl(ALUCtl), .ALUSrc(ALUSrc), .RegDst(RegDst), .RegWrite_in(RegWrite_in),
    .MemtoReg_in(MemtoReg_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .Branch_in(Branch_in), .PCAddResult(PCAddResult), .ReadData1(ReadData1),
    .ReadData2_in(ReadData2_in), .SignExtResult(SignExtResult), .rt(rt), .rd(rd),
    .FwdA(FwdA), .FwdB(FwdB), .FwdMem(FwdMem), .FwdWb(FwdWb), .out_valid(out_valid),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out), .MemRead_out(MemRead_out),
    .MemWrite_out(MemWrite_out), .Branch_out(Branch_out), .BranchTarget(BranchTarget),
    .ALUResult(ALUResult), .Zero(Zero), .WriteData(WriteData), .WriteReg(WriteReg)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwdSel(input logic [1:0] s, input logic [31:0] r,
                                         input logic [31:0] m, input logic [31:0] w);
    if (s == 2'b10) return m;
    if (s == 2'b01) return w;
    return r;
  endfunction

  function automatic logic [31:0] refAlu(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b, input int sh);
    case (c)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a - b;
      4'd4:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5:  return ~(a | b);
      4'd6:  return a ^ b;
      4'd7:  return b << sh;
      4'd8:  return b >> sh;
      4'd9:  return $signed(b) >>> sh;
      4'd12: return mHi;
      4'd13: return mLo;
      4'd14: return (a < b) ? 32'd1 : 32'd0;
      4'd15: return b << 16;
      default: return 32'd0;
    endcase
  endfunction

  task automatic randomFields();
    ALUSrc = 1'($urandom);        RegDst = 1'($urandom);
    RegWrite_in = 1'($urandom);   MemtoReg_in = 1'($urandom);
    MemRead_in = 1'($urandom);    MemWrite_in = 1'($urandom);
    Branch_in = 1'($urandom);     PCAddResult = $urandom;
    ReadData1 = $urandom;         ReadData2_in = $urandom;
    SignExtResult = $urandom;     rt = 5'($urandom);
    rd = 5'($urandom);            FwdA = 2'($urandom);
    FwdB = 2'($urandom);          FwdMem = $urandom;
    FwdWb = $urandom;
  endtask

  task automatic plainOperands(input logic [31:0] a, input logic [31:0] b);
    ReadData1 = a; ReadData2_in = b; FwdA = 2'b00; FwdB = 2'b00; ALUSrc = 1'b0;
  endtask

  // Issue one single-cycle op and check every EX/MEM field one edge later
  task automatic runSingle(input logic [3:0] ctl);
    logic [31:0] a, bf, b, e;
    @(negedge Clk);
    ALUCtl = ctl; in_valid = 1'b1;
    a  = fwdSel(FwdA, ReadData1, FwdMem, FwdWb);
    bf = fwdSel(FwdB, ReadData2_in, FwdMem, FwdWb);
    b  = ALUSrc ? SignExtResult : bf;
    e  = refAlu(ctl, a, b, int'(SignExtResult[10:6]));
    @(posedge Clk); #1;
    in_valid = 1'b0;
    check("out_valid", 32'(out_valid), 32'd1);
    check("ALUResult", ALUResult, e);
    check("Zero", 32'(Zero), 32'(e == 32'd0));
    check("ctrl", 32'({RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, Branch_out}),
          32'({RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, Branch_in}));
    check("BranchTarget", BranchTarget, PCAddResult + (SignExtResult << 2));
    check("WriteData", WriteData, bf);
    check("WriteReg", 32'(WriteReg), 32'(RegDst ? rd : rt));
  endtask

  // Issue MULTU/DIVU, scramble the inputs, then check stall length and completion
  task automatic runMulDiv(input logic [3:0] ctl);
    logic [31:0] a, b, eHi, eLo;
    logic [63:0] p;
    logic        eMtr;
    logic [4:0]  eWr;
    int          cnt, early;
    @(negedge Clk);
    ALUCtl = ctl; in_valid = 1'b1;
    a = fwdSel(FwdA, ReadData1, FwdMem, FwdWb);
    b = ALUSrc ? SignExtResult : fwdSel(FwdB, ReadData2_in, FwdMem, FwdWb);
    if (ctl == 4'd10) begin
      p = {32'd0, a} * {32'd0, b};
      eHi = p[63:32]; eLo = p[31:0];
    end else if (b == 32'd0) begin
      eHi = a; eLo = 32'hFFFF_FFFF;
    end else begin
      eHi = a % b; eLo = a / b;
    end
    eMtr = MemtoReg_in;
    eWr  = RegDst ? rd : rt;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    randomFields();
    cnt = 0; early = 0;
    while (in_ready === 1'b0 && cnt < 40) begin
      cnt++;
      if (out_valid !== 1'b0) early++;
      @(posedge Clk); #1;
    end
    check("busy_cycles", 32'(cnt), 32'd32);
    check("early_out_valid", 32'(early), 32'd0);
    check("md_out_valid", 32'(out_valid), 32'd1);
    check("md_ALUResult", ALUResult, eLo);
    check("md_ctrl_forced", 32'({RegWrite_out, MemRead_out, MemWrite_out, Branch_out}), 32'd0);
    check("md_MemtoReg", 32'(MemtoReg_out), 32'(eMtr));
    check("md_WriteReg", 32'(WriteReg), 32'(eWr));
    mHi = eHi; mLo = eLo;
  endtask

  initial begin
    Reset = 1'b0; Flush = 1'b0; in_valid = 1'b0; ALUCtl = 4'd0;
    ALUSrc = 1'b0; RegDst = 1'b0; RegWrite_in = 1'b0; MemtoReg_in = 1'b0;
    MemRead_in = 1'b0; MemWrite_in = 1'b0; Branch_in = 1'b0; PCAddResult = '0;
    ReadData1 = '0; ReadData2_in = '0; SignExtResult = '0; rt = '0; rd = '0;
    FwdA = '0; FwdB = '0; FwdMem = '0; FwdWb = '0;

    // Reset state
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ALUResult", ALUResult, 32'd0);
    check("rst_Zero", 32'(Zero), 32'd1);
    check("rst_BranchTarget", BranchTarget, 32'd0);
    check("rst_WriteData", WriteData, 32'd0);
    check("rst_WriteReg", 32'(WriteReg), 32'd0);
    check("rst_ctrl", 32'({RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, Branch_out}),
          32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("ready_after_reset", 32'(in_ready), 32'd1);
    runSingle(4'd12);
    runSingle(4'd13);

    // ADD with FwdMem forwarding into A, then SUB 3-3
    randomFields();
    plainOperands(32'd0, 32'd3); FwdA = 2'b10; FwdMem = 32'h5;
    runSingle(4'd2);
    plainOperands(32'd3, 32'd3);
    runSingle(4'd3);
    // Branch target wrap and arithmetic shift
    randomFields();
    PCAddResult = 32'h100; SignExtResult = 32'hFFFF_FFFF;
    runSingle(4'd0);
    check("branch_target_dir", BranchTarget, 32'h0000_00FC);
    plainOperands(32'd0, 32'h8000_0000); SignExtResult = 32'd4 << 6;
    runSingle(4'd9);
    check("sra_dir", ALUResult, 32'hF800_0000);

    // Random single-cycle ops across all forwarding paths
    repeat (60) begin
      logic [3:0] c;
      randomFields();
      c = 4'($urandom_range(0, 15));
      if (c == 4'd10 || c == 4'd11) c = 4'd2;
      runSingle(c);
    end

    // Directed MULTU and DIVU cases, each followed by MFHI/MFLO
    randomFields(); plainOperands(32'hFFFF_FFFF, 32'd2);
    runMulDiv(4'd10); runSingle(4'd12);
    check("multu_hi_dir", ALUResult, 32'h1);
    runSingle(4'd13);
    check("multu_lo_dir", ALUResult, 32'hFFFF_FFFE);
    randomFields(); plainOperands(32'd7, 32'd0);
    runMulDiv(4'd11); runSingle(4'd12); runSingle(4'd13);
    randomFields(); plainOperands(32'd100, 32'd7);
    runMulDiv(4'd11); runSingle(4'd12);
    check("divu_hi_dir", ALUResult, 32'd2);
    runSingle(4'd13);
    check("divu_lo_dir", ALUResult, 32'd14);

    // Random MULTU/DIVU, including small divisors
    repeat (8) begin
      randomFields();
      if ($urandom_range(0, 1) == 0) plainOperands($urandom, $urandom_range(1, 1000));
      runMulDiv($urandom_range(0, 1) == 0 ? 4'd10 : 4'd11);
      runSingle(4'd12); runSingle(4'd13);
    end

    // Flush in IDLE kills the accept
    randomFields();
    @(negedge Clk);
    ALUCtl = 4'd2; in_valid = 1'b1; Flush = 1'b1; RegWrite_in = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0; Flush = 1'b0;
    check("flush_idle_valid", 32'(out_valid), 32'd0);
    check("flush_idle_regwrite", 32'(RegWrite_out), 32'd0);
    check("flush_idle_ready", 32'(in_ready), 32'd1);

    // Flush during cycle 10 of a DIVU
    randomFields(); plainOperands(32'd1000, 32'd3);
    @(negedge Clk);
    ALUCtl = 4'd11; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge Clk);
    #1;
    check("div_busy_before_flush", 32'(in_ready), 32'd0);
    @(negedge Clk); Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    check("flush_busy_ready", 32'(in_ready), 32'd1);
    check("flush_busy_valid", 32'(out_valid), 32'd0);
    begin
      int pulses = 0;
      repeat (30) begin
        @(posedge Clk); #1;
        if (out_valid !== 1'b0) pulses++;
      end
      check("flush_no_completion", 32'(pulses), 32'd0);
    end
    runSingle(4'd12); runSingle(4'd13);

    // Asynchronous reset mid-MULTU
    randomFields(); plainOperands(32'h1234_5678, 32'h9ABC_DEF0);
    runSingle(4'd2);
    plainOperands(32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge Clk);
    ALUCtl = 4'd10; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_ALUResult", ALUResult, 32'd0);
    check("arst_Zero", 32'(Zero), 32'd1);
    check("arst_BranchTarget", BranchTarget, 32'd0);
    check("arst_WriteData", WriteData, 32'd0);
    check("arst_ctrl", 32'({RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, Branch_out}),
          32'd0);
    mHi = '0; mLo = '0;
    @(negedge Clk); Reset = 1'b1;
    @(posedge Clk); #1;
    check("arst_ready", 32'(in_ready), 32'd1);
    randomFields();
    runSingle(4'd2);
    runSingle(4'd12);
    runSingle(4'd13);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/ex_stage_muldiv.md
# ex_stage_muldiv

Parametrised execute stage for the pipelined MIPS datapath, sitting between the ID/EX and EX/MEM boundaries. It contains the forwarding operand muxes, ALUSrc/RegDst selection, the branch-target adder, a single-cycle ALU, an iterative unsigned multiply/divide unit with HI/LO registers, and the registered EX/MEM outputs. Multi-cycle ops stall the front end through a valid/ready handshake, and a flush input aborts in-flight work.

## Interface
- DATA_W, 32: datapath width (≥8, even)
- REG_ADDR_W, 5: register-specifier width
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Flush  in  1  synchronous kill of the accepting slot, any in-flight mul/div, and the next output
- in_valid  in  1  ID/EX holds a valid instruction
- in_ready  out  1  EX can accept; high only in IDLE
- ALUCtl  in  4  operation (see Operation)
- ALUSrc, RegDst  in  1 each  B = SignExtResult / dest = rd
- RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, Branch_in  in  1 each  control bits passed to MEM
- PCAddResult  in  DATA_W  PC+4
- ReadData1, ReadData2_in  in  DATA_W  register-file operands
- SignExtResult  in  DATA_W  immediate; bits [10:6] = shamt
- rt, rd  in  REG_ADDR_W  destination candidates
- FwdA, FwdB  in  2  00 = register file, 10 = FwdMem, 01 = FwdWb, 11 = register file
- FwdMem, FwdWb  in  DATA_W  forwarded values from EX/MEM and MEM/WB
- out_valid  out  1  EX/MEM slot holds an instruction
- RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, Branch_out  out  1 each  registered controls
- BranchTarget  out  DATA_W  PC+4 + (imm<<2)
- ALUResult  out  DATA_W  result
- Zero  out  1  ALUResult == 0
- WriteData  out  DATA_W  forwarded B operand, before the ALUSrc mux, for stores
- WriteReg  out  REG_ADDR_W  selected destination

## Operation
- A = Fwd-mux(ReadData1, FwdA). Bfwd = Fwd-mux(ReadData2_in, FwdB). B = ALUSrc ? SignExtResult : Bfwd.
- ALUCtl:
  - 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT (signed), 5 NOR, 6 XOR
  - 7 SLL, 8 SRL, 9 SRA: shift B by shamt
  - 10 MULTU, 11 DIVU, 12 MFHI, 13 MFLO, 14 SLTU, 15 LUI (B<<16)
- All arithmetic is modulo 2^DATA_W. No overflow traps.
- BranchTarget wraps modulo 2^DATA_W.
- Accept happens on a rising edge with in_valid & in_ready & ~Flush. Without an accept, out_valid=0 and all control outputs are 0 (bubble).
- FSM states: IDLE, MUL, DIV.
  - IDLE→MUL or IDLE→DIV on accepting ALUCtl 10/11. A and B are latched and a counter loads DATA_W.
  - Each cycle performs one shift-add (MUL) or restoring step (DIV) and decrements the counter.
  - At counter 1→0: HI/LO are written and the FSM returns to IDLE.
  - MULTU: {HI,LO} = A*B (2·DATA_W product).
  - DIVU: LO = A/B, HI = A%B.
  - Divide by zero: LO = all ones, HI = A. This is not an error.
- On completion the mul/div instruction emits out_valid=1 with RegWrite_out, MemRead_out, MemWrite_out and Branch_out forced to 0, and ALUResult = LO.
- MFHI/MFLO read the HI/LO registers. The value visible is the one after any completed mul/div, with no hazard window.
- Flush:
  - In IDLE it blocks the accept, giving a bubble.
  - In MUL/DIV it returns the FSM to IDLE at the next edge, leaves HI/LO unchanged, and emits no completion output.

## Timing
- Reset asserted (async) forces:
  - every output register to 0: out_valid, all control outputs, BranchTarget, ALUResult, WriteData, WriteReg
  - Zero=1, since it is derived from ALUResult=0
  - HI=LO=0, state IDLE, counter 0
- in_ready=1 from the first cycle after reset deassertion.
- Single-cycle ops: 1-cycle latency. Inputs accepted at edge N appear on the outputs after edge N.
- MULTU/DIVU:
  - Accepted at edge N.
  - in_ready=0 during the cycles after edges N … N+DATA_W−1.
  - Completion output and HI/LO update occur at edge N+DATA_W.
  - in_ready=1 after edge N+DATA_W. Earliest next accept is at edge N+DATA_W+1.
- in_ready is combinational from state only. It does not depend on in_valid.
- Upstream holds ID/EX inputs while in_ready=0. Operand changes during MUL/DIV have no effect.
- Flush and an accept in the same cycle: Flush wins.
- Flush and completion in the same cycle: Flush wins. HI/LO are not written.
- Reset mid-mul/div: immediate abort, and HI/LO are cleared.

## Test plan
- ADD with FwdA=10, FwdMem=0x0000_0005, ReadData2_in=0x0000_0003 → next cycle ALUResult=0x8, Zero=0, out_valid=1. SUB 3−3 → Zero=1.
- Branch with PCAddResult=0x0000_0100, SignExtResult=0xFFFF_FFFF → BranchTarget=0x0000_00FC. SRA of B=0x8000_0000, shamt 4 → 0xF800_0000.
- MULTU 0xFFFF_FFFF×0x2:
  - in_ready low for exactly 32 cycles
  - then out_valid=1, RegWrite_out=0
  - MFHI issued next → 0x1, MFLO → 0xFFFF_FFFE
- DIVU 7/0 → LO=0xFFFF_FFFF, HI=0x7. DIVU 100/7 → LO=14, HI=2.
- Flush asserted on cycle 10 of a DIVU → FSM IDLE next cycle, HI/LO unchanged, no out_valid pulse, in_ready=1.
- Reset pulsed low mid-MULTU → all outputs 0 asynchronously, HI=LO=0. After release, in_ready=1 and a new ADD completes in 1 cycle.
